// File: rtl/aurora_rx_frame_filter.sv
// aurora_rx_frame_filter: CRC-gated Aurora RX frame buffer; define AURORA_RX_FRAME_STATS_EN for statistics counters
module aurora_rx_frame_filter #(
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_FRAME_WORDS = 128
) (
  input  logic        userClk,
  input  logic        reset,
  input  logic [63:0] axiRXtdata,
  input  logic [7:0]  axiRXtkeep,
  input  logic        axiRXtlast,
  input  logic        axiRXtValid,
  input  logic        axiCrcPass,
  input  logic        axiCrcValid,
  output logic [63:0] outTdata,
  output logic [7:0]  outTkeep,
  output logic        outTlast,
  output logic        outTvalid,
  input  logic        outTready,
  output logic        frameDropped,
  input  logic        statsClear,
  output logic [15:0] goodFrameCount,
  output logic [15:0] crcErrCount,
  output logic [15:0] dropCount
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MAX_FRAME_WORDS);
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  state_t state, stateNext;
  logic [72:0] mem [DEPTH];
  logic [72:0] aData;
  logic [ADDR_WIDTH:0] wrPtr, commitPtr, rdPtr, fetchPtr, frameLen, beatNum;
  logic rxArmed, beat, overflow, crcGood, doWrite, doCommit, crcFail, lenDrop;
  logic aValid, outFree, fetch;

  assign beat = axiRXtValid && rxArmed;
  assign beatNum = (state == RECV ? frameLen : '0) + ONE;
  assign overflow = (wrPtr - rdPtr == FULL_LEVEL) || (beatNum > MAX_LEN);
  assign crcGood = axiCrcValid && axiCrcPass;

  // next state and per-beat write/commit/drop decisions
  always_comb begin
    stateNext = state;
    doWrite = 1'b0;
    doCommit = 1'b0;
    crcFail = 1'b0;
    lenDrop = 1'b0;
    if (beat) begin
      if (state == DROP) begin
        stateNext = axiRXtlast ? IDLE : DROP;
      end else if (overflow) begin
        lenDrop = 1'b1;
        stateNext = axiRXtlast ? IDLE : DROP;
      end else begin
        doWrite = 1'b1;
        doCommit = axiRXtlast && crcGood;
        crcFail = axiRXtlast && !crcGood;
        stateNext = axiRXtlast ? IDLE : RECV;
      end
    end
  end

  // FSM state, speculative/commit pointers and the drop pulse
  always_ff @(posedge userClk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wrPtr <= '0;
      commitPtr <= '0;
      frameLen <= '0;
      rxArmed <= 1'b0;
      frameDropped <= 1'b0;
    end else begin
      state <= stateNext;
      rxArmed <= 1'b1;
      frameDropped <= crcFail || lenDrop;
      if (doWrite) frameLen <= beatNum;
      if (doCommit) commitPtr <= wrPtr + ONE;
      wrPtr <= (crcFail || lenDrop) ? commitPtr : doWrite ? wrPtr + ONE : wrPtr;
    end
  end

  // buffer write port; contents are never reset
  always_ff @(posedge userClk) begin
    if (doWrite) mem[wrPtr[ADDR_WIDTH-1:0]] <= {axiRXtlast, axiRXtkeep, axiRXtdata};
  end

  assign outFree = !outTvalid || outTready;
  assign fetch = (fetchPtr != commitPtr) && (!aValid || outFree);

  // read pipeline: registered buffer read, then output register; rdPtr frees space only on handshake
  always_ff @(posedge userClk or posedge reset) begin
    if (reset) begin
      fetchPtr <= '0;
      rdPtr <= '0;
      aValid <= 1'b0;
      aData <= '0;
      outTvalid <= 1'b0;
      outTlast <= 1'b0;
      outTkeep <= '0;
      outTdata <= '0;
    end else begin
      if (fetch) aData <= mem[fetchPtr[ADDR_WIDTH-1:0]];
      if (fetch) fetchPtr <= fetchPtr + ONE;
      aValid <= fetch || (aValid && !outFree);
      if (outFree) outTvalid <= aValid;
      if (outFree && aValid) {outTlast, outTkeep, outTdata} <= aData;
      if (outTvalid && outTready) rdPtr <= rdPtr + ONE;
    end
  end

`ifdef AURORA_RX_FRAME_STATS_EN
  // saturating statistics; a clear wins over a same-cycle increment
  always_ff @(posedge userClk or posedge reset) begin
    if (reset) begin
      goodFrameCount <= '0;
      crcErrCount <= '0;
      dropCount <= '0;
    end else if (statsClear) begin
      goodFrameCount <= '0;
      crcErrCount <= '0;
      dropCount <= '0;
    end else begin
      if (doCommit && goodFrameCount != 16'hFFFF) goodFrameCount <= goodFrameCount + 16'd1;
      if (crcFail && crcErrCount != 16'hFFFF) crcErrCount <= crcErrCount + 16'd1;
      if (lenDrop && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
    end
  end
`else
  logic unusedStatsClear;
  assign unusedStatsClear = statsClear;
  assign goodFrameCount = '0;
  assign crcErrCount = '0;
  assign dropCount = '0;
`endif
endmodule

// File: tb/tb_aurora_rx_frame_filter.sv
// tb_aurora_rx_frame_filter: directed bench (ADDR_WIDTH=3, MAX_FRAME_WORDS=4); counter checks follow AURORA_RX_FRAME_STATS_EN
module tb_aurora_rx_frame_filter;
  logic userClk = 1'b0;
  logic reset = 1'b0;
  logic [63:0] axiRXtdata = '0;
  logic [7:0] axiRXtkeep = '0;
  logic axiRXtlast = 1'b0, axiRXtValid = 1'b0, axiCrcPass = 1'b0, axiCrcValid = 1'b0;
  logic [63:0] outTdata;
  logic [7:0] outTkeep;
  logic outTlast, outTvalid;
  logic outTready = 1'b1;
  logic frameDropped;
  logic statsClear = 1'b0;
  logic [15:0] goodFrameCount, crcErrCount, dropCount;
  int tests = 0, fails = 0, dropPulses = 0, cycle = 0;
  logic [72:0] got[$];
  int gotCycle[$];
`ifdef AURORA_RX_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  aurora_rx_frame_filter #(.ADDR_WIDTH(3), .MAX_FRAME_WORDS(4)) dut (
    .userClk(userClk), .reset(reset),
    .axiRXtdata(axiRXtdata), .axiRXtkeep(axiRXtkeep), .axiRXtlast(axiRXtlast), .axiRXtValid(axiRXtValid),
    .axiCrcPass(axiCrcPass), .axiCrcValid(axiCrcValid),
    .outTdata(outTdata), .outTkeep(outTkeep), .outTlast(outTlast), .outTvalid(outTvalid), .outTready(outTready),
    .frameDropped(frameDropped), .statsClear(statsClear),
    .goodFrameCount(goodFrameCount), .crcErrCount(crcErrCount), .dropCount(dropCount)
  );

  always #5 userClk = ~userClk;

  always @(posedge userClk) cycle <= cycle + 1;

  always @(negedge userClk) begin
    if (outTvalid && outTready) begin
      got.push_back({outTlast, outTkeep, outTdata});
      gotCycle.push_back(cycle);
    end
    if (frameDropped) dropPulses++;
  end

  function automatic logic [72:0] word(input logic [63:0] base, input int i, input int n);
    return {i == n - 1, (i == n - 1) ? 8'h0F : 8'hFF, base + 64'(i)};
  endfunction

  function automatic logic [72:0] gotAt(input int i);
    return (i < got.size()) ? got[i] : 'x;
  endfunction

  task automatic rxIdle();
    @(posedge userClk);
    #1;
    axiRXtValid = 1'b0;
    axiRXtlast = 1'b0;
    axiCrcValid = 1'b0;
    axiCrcPass = 1'b0;
  endtask

  task automatic sendBeat(input logic [63:0] d, input logic last, input logic crcOk);
    @(posedge userClk);
    #1;
    axiRXtValid = 1'b1;
    axiRXtdata = d;
    axiRXtkeep = last ? 8'h0F : 8'hFF;
    axiRXtlast = last;
    axiCrcValid = last;
    axiCrcPass = crcOk;
  endtask

  task automatic sendFrame(input int n, input logic [63:0] base, input logic crcOk);
    for (int i = 0; i < n; i++) sendBeat(base + 64'(i), i == n - 1, crcOk);
    rxIdle();
  endtask

  task automatic doReset();
    @(posedge userClk);
    #3;
    reset = 1'b1;
    axiRXtValid = 1'b0;
    axiRXtlast = 1'b0;
    outTready = 1'b1;
    statsClear = 1'b0;
    repeat (2) @(posedge userClk);
    #1;
    reset = 1'b0;
    got.delete();
    gotCycle.delete();
    dropPulses = 0;
    repeat (3) @(posedge userClk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({outTvalid, outTlast, outTkeep, outTdata, frameDropped} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got valid=%b last=%b keep=%h data=%h drop=%b, want all 0", outTvalid, outTlast, outTkeep, outTdata, frameDropped);
    end
    tests++;
    if ({goodFrameCount, crcErrCount, dropCount} !== 48'h0) begin
      fails++;
      $display("FAIL reset_counters got %h/%h/%h want 0/0/0", goodFrameCount, crcErrCount, dropCount);
    end
    axiRXtValid = 1'b1;
    axiRXtdata = 64'hDEAD;
    axiRXtkeep = 8'h0F;
    axiRXtlast = 1'b1;
    axiCrcValid = 1'b1;
    axiCrcPass = 1'b1;
    @(posedge userClk);
    #1;
    reset = 1'b0;
    rxIdle();
    repeat (6) @(posedge userClk);
    #1;
    tests++;
    if (got.size() !== 0) begin
      fails++;
      $display("FAIL first_cycle_ignore got %0d beats out, want 0", got.size());
    end
  endtask

  task automatic test_good_frame();
    doReset();
    sendFrame(4, 64'h1000, 1'b1);
    @(negedge userClk);
    tests++;
    if (outTvalid !== 1'b0) begin fails++; $display("FAIL latency_c0 valid=%b want 0", outTvalid); end
    @(negedge userClk);
    tests++;
    if (outTvalid !== 1'b0) begin fails++; $display("FAIL latency_c1 valid=%b want 0", outTvalid); end
    @(negedge userClk);
    tests++;
    if (outTvalid !== 1'b1 || outTdata !== 64'h1000) begin
      fails++;
      $display("FAIL latency_c2 valid=%b data=%h want 1 1000", outTvalid, outTdata);
    end
    repeat (8) @(posedge userClk);
    #1;
    tests++;
    if (got.size() !== 4) begin fails++; $display("FAIL good_count_beats got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (gotAt(i) !== word(64'h1000, i, 4)) begin
        fails++;
        $display("FAIL good_beat%0d got %h want %h", i, gotAt(i), word(64'h1000, i, 4));
      end
    end
    tests++;
    if (goodFrameCount !== (STATS ? 16'd1 : 16'd0) || dropPulses !== 0) begin
      fails++;
      $display("FAIL good_stats good=%0d pulses=%0d want %0d 0", goodFrameCount, dropPulses, STATS);
    end
  endtask

  task automatic test_crc_error();
    doReset();
    sendFrame(3, 64'h2000, 1'b0);
    tests++;
    if (frameDropped !== 1'b1) begin fails++; $display("FAIL crc_pulse_on got %b want 1", frameDropped); end
    @(posedge userClk);
    #1;
    tests++;
    if (frameDropped !== 1'b0) begin fails++; $display("FAIL crc_pulse_off got %b want 0", frameDropped); end
    sendFrame(2, 64'h3000, 1'b1);
    repeat (8) @(posedge userClk);
    #1;
    tests++;
    if (got.size() !== 2 || dropPulses !== 1) begin
      fails++;
      $display("FAIL crc_counts beats=%0d pulses=%0d want 2 1", got.size(), dropPulses);
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (gotAt(i) !== word(64'h3000, i, 2)) begin
        fails++;
        $display("FAIL crc_beat%0d got %h want %h", i, gotAt(i), word(64'h3000, i, 2));
      end
    end
    tests++;
    if (crcErrCount !== (STATS ? 16'd1 : 16'd0) || dropCount !== 16'd0 || goodFrameCount !== (STATS ? 16'd1 : 16'd0)) begin
      fails++;
      $display("FAIL crc_stats crc=%0d drop=%0d good=%0d want %0d 0 %0d", crcErrCount, dropCount, goodFrameCount, STATS, STATS);
    end
  endtask

  task automatic test_too_long();
    doReset();
    sendFrame(6, 64'h4000, 1'b1);
    sendFrame(1, 64'h5000, 1'b1);
    repeat (8) @(posedge userClk);
    #1;
    tests++;
    if (got.size() !== 1 || gotAt(0) !== word(64'h5000, 0, 1)) begin
      fails++;
      $display("FAIL long_output beats=%0d first=%h want 1 %h", got.size(), gotAt(0), word(64'h5000, 0, 1));
    end
    tests++;
    if (dropPulses !== 1 || dropCount !== (STATS ? 16'd1 : 16'd0) || crcErrCount !== 16'd0) begin
      fails++;
      $display("FAIL long_stats pulses=%0d drop=%0d crc=%0d want 1 %0d 0", dropPulses, dropCount, crcErrCount, STATS);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    outTready = 1'b0;
    sendFrame(3, 64'h6000, 1'b1);
    sendFrame(3, 64'h7000, 1'b1);
    sendFrame(3, 64'h8000, 1'b1);
    repeat (4) @(posedge userClk);
    #1;
    tests++;
    if (outTvalid !== 1'b1 || {outTlast, outTkeep, outTdata} !== word(64'h6000, 0, 3)) begin
      fails++;
      $display("FAIL stall_first valid=%b beat=%h want 1 %h", outTvalid, {outTlast, outTkeep, outTdata}, word(64'h6000, 0, 3));
    end
    repeat (3) @(posedge userClk);
    #1;
    tests++;
    if (outTvalid !== 1'b1 || {outTlast, outTkeep, outTdata} !== word(64'h6000, 0, 3)) begin
      fails++;
      $display("FAIL stall_hold valid=%b beat=%h want 1 %h", outTvalid, {outTlast, outTkeep, outTdata}, word(64'h6000, 0, 3));
    end
    tests++;
    if (dropPulses !== 1 || dropCount !== (STATS ? 16'd1 : 16'd0) || goodFrameCount !== (STATS ? 16'd2 : 16'd0)) begin
      fails++;
      $display("FAIL full_stats pulses=%0d drop=%0d good=%0d want 1 %0d %0d", dropPulses, dropCount, goodFrameCount, STATS, 2 * STATS);
    end
    outTready = 1'b1;
    repeat (10) @(posedge userClk);
    #1;
    tests++;
    if (got.size() !== 6) begin fails++; $display("FAIL full_beats got %0d want 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (gotAt(i) !== word(i < 3 ? 64'h6000 : 64'h7000, i % 3, 3)) begin
        fails++;
        $display("FAIL full_beat%0d got %h want %h", i, gotAt(i), word(i < 3 ? 64'h6000 : 64'h7000, i % 3, 3));
      end
    end
    tests++;
    if (gotCycle.size() !== 6 || gotCycle[5] - gotCycle[0] !== 5) begin
      fails++;
      $display("FAIL sustain_rate beats=%0d span=%0d want 6 5", gotCycle.size(), gotCycle.size() == 6 ? gotCycle[5] - gotCycle[0] : -1);
    end
    sendFrame(2, 64'h9000, 1'b1);
    repeat (8) @(posedge userClk);
    #1;
    tests++;
    if (got.size() !== 8 || gotAt(6) !== word(64'h9000, 0, 2) || gotAt(7) !== word(64'h9000, 1, 2)) begin
      fails++;
      $display("FAIL wrap_frame beats=%0d b6=%h b7=%h want 8 %h %h", got.size(), gotAt(6), gotAt(7), word(64'h9000, 0, 2), word(64'h9000, 1, 2));
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    sendBeat(64'hA100, 1'b0, 1'b0);
    sendBeat(64'hA101, 1'b0, 1'b0);
    @(posedge userClk);
    #3;
    reset = 1'b1;
    axiRXtValid = 1'b0;
    #1;
    tests++;
    if ({outTvalid, outTlast, outTkeep, outTdata, frameDropped} !== '0) begin
      fails++;
      $display("FAIL reset_midframe valid=%b data=%h want 0 0", outTvalid, outTdata);
    end
    @(posedge userClk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge userClk);
    #1;
    sendFrame(4, 64'hA000, 1'b1);
    repeat (3) @(posedge userClk);
    #1;
    tests++;
    if (outTvalid !== 1'b1) begin fails++; $display("FAIL readout_active valid=%b want 1", outTvalid); end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({outTvalid, outTlast, outTkeep, outTdata} !== '0) begin
      fails++;
      $display("FAIL reset_midread valid=%b last=%b keep=%h data=%h want 0", outTvalid, outTlast, outTkeep, outTdata);
    end
    got.delete();
    @(posedge userClk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge userClk);
    #1;
    sendFrame(2, 64'hB000, 1'b1);
    repeat (8) @(posedge userClk);
    #1;
    tests++;
    if (got.size() !== 2 || gotAt(0) !== word(64'hB000, 0, 2) || gotAt(1) !== word(64'hB000, 1, 2)) begin
      fails++;
      $display("FAIL after_reset beats=%0d b0=%h b1=%h want 2 %h %h", got.size(), gotAt(0), gotAt(1), word(64'hB000, 0, 2), word(64'hB000, 1, 2));
    end
    tests++;
    if (goodFrameCount !== (STATS ? 16'd1 : 16'd0)) begin
      fails++;
      $display("FAIL after_reset_good got %0d want %0d", goodFrameCount, STATS);
    end
  endtask

  task automatic test_stats();
    doReset();
`ifdef AURORA_RX_FRAME_STATS_EN
    force dut.goodFrameCount = 16'hFFFF;
    force dut.crcErrCount = 16'hFFFF;
    force dut.dropCount = 16'hFFFF;
    @(posedge userClk);
    #1;
    release dut.goodFrameCount;
    release dut.crcErrCount;
    release dut.dropCount;
`endif
    sendFrame(1, 64'hC000, 1'b1);
    sendFrame(2, 64'hC100, 1'b0);
    sendFrame(5, 64'hC200, 1'b1);
    repeat (2) @(posedge userClk);
    #1;
    tests++;
    if ({goodFrameCount, crcErrCount, dropCount} !== (STATS ? 48'hFFFF_FFFF_FFFF : 48'h0)) begin
      fails++;
      $display("FAIL saturate got %h/%h/%h want %h", goodFrameCount, crcErrCount, dropCount, STATS ? 16'hFFFF : 16'h0);
    end
    sendBeat(64'hD000, 1'b1, 1'b1);
    statsClear = 1'b1;
    rxIdle();
    statsClear = 1'b0;
    @(posedge userClk);
    #1;
    tests++;
    if ({goodFrameCount, crcErrCount, dropCount} !== 48'h0) begin
      fails++;
      $display("FAIL clear_priority got %h/%h/%h want 0/0/0", goodFrameCount, crcErrCount, dropCount);
    end
    sendFrame(1, 64'hE000, 1'b1);
    repeat (6) @(posedge userClk);
    #1;
    tests++;
    if (goodFrameCount !== (STATS ? 16'd1 : 16'd0) || got.size() !== 3) begin
      fails++;
      $display("FAIL post_clear good=%0d beats=%0d want %0d 3", goodFrameCount, got.size(), STATS);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    test_reset();
    test_good_frame();
    test_crc_error();
    test_too_long();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aurora_rx_frame_filter.md
AURORA_RX_FRAME_FILTER -- requirements
Module: aurora_rx_frame_filter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, meaning buffer depth = 2^ADDR_WIDTH 73-bit entries (64 data, 8 keep, 1 last).
REQ-002 SHALL have parameter MAX_FRAME_WORDS, default 128, meaning the longest accepted frame in 64-bit beats (1..2^ADDR_WIDTH-1).
REQ-003 SHALL have port userClk, input, 1, Aurora user clock; the only clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports axiRXtdata in 64, axiRXtkeep in 8, axiRXtlast in 1, axiRXtValid in 1: Aurora RX stream, no backpressure.
REQ-006 SHALL have ports axiCrcPass in 1, axiCrcValid in 1: Aurora CRC result, valid on the tlast beat.
REQ-007 SHALL have ports outTdata out 64, outTkeep out 8, outTlast out 1, outTvalid out 1, outTready in 1: AXI-S master of committed frames.
REQ-008 SHALL have port frameDropped, output, 1, one-cycle pulse per discarded frame.
REQ-009 SHALL have port statsClear, input, 1, synchronous clear of statistics counters.
REQ-010 SHALL have ports goodFrameCount, crcErrCount, dropCount, output, 16 each, statistics.

Function
REQ-011 SHALL keep wrPtr (speculative), commitPtr, rdPtr, each ADDR_WIDTH+1 bits, wrapping modulo 2^(ADDR_WIDTH+1); full when wrPtr-rdPtr = 2^ADDR_WIDTH.
REQ-012 SHALL implement states IDLE, RECV, DROP; any axiRXtValid beat in IDLE writes the beat and enters RECV, or is evaluated immediately if tlast.
REQ-013 SHALL write each valid beat at wrPtr and increment wrPtr in IDLE/RECV while not full and beat count <= MAX_FRAME_WORDS.
REQ-014 SHALL, on a tlast beat with axiCrcValid=1 and axiCrcPass=1, set commitPtr to the post-write wrPtr on that edge, increment goodFrameCount, return to IDLE.
REQ-015 SHALL, on a tlast beat with axiCrcValid=0 or axiCrcPass=0, rewind wrPtr to commitPtr, pulse frameDropped next cycle, increment crcErrCount, return to IDLE.
REQ-016 SHALL, when a beat arrives with buffer full or frame length would exceed MAX_FRAME_WORDS, rewind wrPtr to commitPtr, pulse frameDropped, increment dropCount, enter DROP (or IDLE if that beat is tlast).
REQ-017 SHALL in DROP ignore all beats until a tlast beat, then return to IDLE without counting a CRC error.
REQ-018 SHALL present committed entries in order; first beat of a frame asserts outTvalid exactly 2 cycles after the commit edge when output is idle.
REQ-019 SHALL hold outTdata/outTkeep/outTlast/outTvalid stable while outTvalid=1 and outTready=0; sustain one beat/cycle when outTready=1 continuously.
REQ-020 SHALL never present entries beyond commitPtr; simultaneous commit and read SHALL both take effect.
REQ-021 SHALL saturate all counters at 0xFFFF; statsClear=1 SHALL zero them, taking priority over a same-cycle increment.

Reset
REQ-022 SHALL, on reset assertion, immediately clear all pointers, state to IDLE, outTvalid, outTlast, outTdata, outTkeep, frameDropped and counters to 0.
REQ-023 SHALL discard any partial or committed-unread frame on reset; buffer contents need not be cleared.
REQ-024 SHALL ignore RX beats in the first cycle after reset deassertion is sampled.

Configuration
REQ-025 SHALL compile counters only when macro AURORA_RX_FRAME_STATS_EN is defined; without it goodFrameCount, crcErrCount, dropCount are constant 0, statsClear ignored; frameDropped and filtering are unaffected.

Verification
REQ-026 SHALL test: 4-beat frame, last beat crcValid=1 crcPass=1, outTready=1 -> same 4 beats out, outTlast on beat 4, first outTvalid 2 cycles after tlast edge, goodFrameCount=1.
REQ-027 SHALL test: 3-beat frame with crcPass=0, then 2-beat good frame -> only 2-beat frame out, frameDropped one pulse, crcErrCount=1.
REQ-028 SHALL test: MAX_FRAME_WORDS=4, 6-beat frame, then good 1-beat frame -> nothing from the first, dropCount=1, 1-beat frame delivered.
REQ-029 SHALL test: ADDR_WIDTH=3, outTready=0, three good 3-beat frames -> two frames buffered (6 entries), third dropped, then outTready=1 delivers 6 beats intact.
REQ-030 SHALL test: reset asserted mid-frame beat 2 and mid-readout -> outputs 0 immediately, next good frame delivered alone.
REQ-031 SHALL test: counters forced to 0xFFFF stay saturated; statsClear coincident with good frame yields goodFrameCount=0.
